// File: rtl/ha_bist_pkg.sv
// Shared types, constants and golden model for the half-adder BIST sequencer.
package ha_bist_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StCheck,
        StDone
    } bist_state_e;

    localparam int unsigned NumVec = 4;

    // fault_class codes
    localparam logic [2:0] FcNone     = 3'd0;
    localparam logic [2:0] FcSumSa0   = 3'd1;
    localparam logic [2:0] FcSumSa1   = 3'd2;
    localparam logic [2:0] FcCarrySa0 = 3'd3;
    localparam logic [2:0] FcCarrySa1 = 3'd4;
    localparam logic [2:0] FcUnknown  = 3'd7;

    // Reference half adder: returns {carry, sum}
    function automatic logic [1:0] ha_golden(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

    // Map per-output failure masks onto a single-stuck-at classification
    function automatic logic [2:0] ha_fault_class(input logic [3:0] sum_mask,
                                                  input logic [3:0] carry_mask);
        if (sum_mask == 4'b0000 && carry_mask == 4'b0000) return FcNone;
        if (sum_mask == 4'b0110 && carry_mask == 4'b0000) return FcSumSa0;
        if (sum_mask == 4'b1001 && carry_mask == 4'b0000) return FcSumSa1;
        if (sum_mask == 4'b0000 && carry_mask == 4'b1000) return FcCarrySa0;
        if (sum_mask == 4'b0000 && carry_mask == 4'b0111) return FcCarrySa1;
        return FcUnknown;
    endfunction

endpackage

// File: rtl/ha_bist_ctrl_if.sv
// Control/status bus of the half-adder BIST sequencer.
// Optional fault_class signal present when HA_BIST_FAULT_CLASS_EN is defined.
interface ha_bist_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [1:0]       first_fail_vec;
    logic             first_fail_valid;
    logic [3:0]       fail_mask;
`ifdef HA_BIST_FAULT_CLASS_EN
    logic [2:0]       fault_class;

    modport master (
        output start, abort,
        input  busy, done, pass, err_count, first_fail_vec, first_fail_valid, fail_mask,
        input  fault_class
    );
    modport slave (
        input  start, abort,
        output busy, done, pass, err_count, first_fail_vec, first_fail_valid, fail_mask,
        output fault_class
    );
`else
    modport master (
        output start, abort,
        input  busy, done, pass, err_count, first_fail_vec, first_fail_valid, fail_mask
    );
    modport slave (
        input  start, abort,
        output busy, done, pass, err_count, first_fail_vec, first_fail_valid, fail_mask
    );
`endif
endinterface

// File: rtl/ha_bist_checker.sv
// Compares the half adder against the golden model and keeps the mismatch record.
// Per-output masks exist only when HA_BIST_FAULT_CLASS_EN is defined.
module ha_bist_checker
    import ha_bist_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             check_en,
    input  logic [1:0]       vec,
    input  logic             ha_sum,
    input  logic             ha_carry,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       first_fail_vec,
    output logic             first_fail_valid,
`ifdef HA_BIST_FAULT_CLASS_EN
    output logic [3:0]       sum_mask,
    output logic [3:0]       carry_mask,
`endif
    output logic [3:0]       fail_mask
);

    logic [1:0] golden;
    logic       sum_bad;
    logic       carry_bad;
    logic       mismatch;

    // Golden compare; only meaningful while the sequencer is in CHECK
    always_comb begin
        golden    = ha_golden(vec[1], vec[0]);
        sum_bad   = ha_sum != golden[0];
        carry_bad = ha_carry != golden[1];
        mismatch  = check_en & (sum_bad | carry_bad);
    end

    // Mismatch record: saturating count, per-vector mask, first failing vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count        <= '0;
            first_fail_vec   <= 2'b00;
            first_fail_valid <= 1'b0;
            fail_mask        <= 4'b0000;
        end else if (clear) begin
            err_count        <= '0;
            first_fail_vec   <= 2'b00;
            first_fail_valid <= 1'b0;
            fail_mask        <= 4'b0000;
        end else if (mismatch) begin
            if (err_count != {CNT_W{1'b1}}) begin
                err_count <= err_count + CNT_W'(1);
            end
            fail_mask[vec] <= 1'b1;
            if (!first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_vec   <= vec;
            end
        end
    end

`ifdef HA_BIST_FAULT_CLASS_EN
    // Which output failed on which vector, for stuck-at classification
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_mask   <= 4'b0000;
            carry_mask <= 4'b0000;
        end else if (clear) begin
            sum_mask   <= 4'b0000;
            carry_mask <= 4'b0000;
        end else if (check_en) begin
            if (sum_bad)   sum_mask[vec]   <= 1'b1;
            if (carry_bad) carry_mask[vec] <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/ha_bist_ctrl.sv
// BIST sequencer: sweeps all four half-adder input vectors PASSES times,
// holding each for SETTLE cycles before a one-cycle check.
// Optional fault classification output enabled by HA_BIST_FAULT_CLASS_EN.
module ha_bist_ctrl
    import ha_bist_pkg::*;
#(
    parameter int unsigned PASSES = 1,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    ha_bist_ctrl_if.slave  bus,
    output logic           ha_a,
    output logic           ha_b,
    input  logic           ha_sum,
    input  logic           ha_carry
);

    localparam int unsigned SetW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned PasW = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [SetW-1:0] SettleLast = SetW'(SETTLE - 1);
    localparam logic [PasW-1:0] PassLast   = PasW'(PASSES - 1);

    bist_state_e      state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [SetW-1:0]  settle_q, settle_d;
    logic [PasW-1:0]  pass_cnt_q, pass_cnt_d;
    logic [1:0]       ha_q, ha_d;
    logic             pass_q, pass_d;
    logic             clear;
    logic             check_en;
    logic [CNT_W-1:0] err_count;
`ifdef HA_BIST_FAULT_CLASS_EN
    logic [3:0]       sum_mask;
    logic [3:0]       carry_mask;
    logic [2:0]       fault_class_q;
`endif

    // State, counters and registered half-adder drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            vec_q      <= 2'b00;
            settle_q   <= '0;
            pass_cnt_q <= '0;
            ha_q       <= 2'b00;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            settle_q   <= settle_d;
            pass_cnt_q <= pass_cnt_d;
            ha_q       <= ha_d;
            pass_q     <= pass_d;
        end
    end

    // Next-state: sweep sequencing, abort handling, result latch
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        settle_d   = settle_q;
        pass_cnt_d = pass_cnt_q;
        pass_d     = pass_q;
        clear      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    clear      = 1'b1;
                    pass_d     = 1'b0;
                    vec_d      = 2'b00;
                    pass_cnt_d = '0;
                    settle_d   = '0;
                    state_d    = StApply;
                end
            end
            StApply: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (settle_q == SettleLast) begin
                    state_d = StCheck;
                end else begin
                    settle_d = settle_q + SetW'(1);
                end
            end
            StCheck: begin
                settle_d = '0;
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    state_d = StApply;
                end else if (pass_cnt_q != PassLast) begin
                    vec_d      = 2'b00;
                    pass_cnt_d = pass_cnt_q + PasW'(1);
                    state_d    = StApply;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                pass_d  = (err_count == '0);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Drive follows the next state so the pins are a clean register output
        ha_d = (state_d == StApply || state_d == StCheck) ? vec_d : 2'b00;
    end

    assign check_en = (state_q == StCheck);

    ha_bist_checker #(
        .CNT_W (CNT_W)
    ) u_checker (
        .clk              (clk),
        .rst_n            (rst_n),
        .clear            (clear),
        .check_en         (check_en),
        .vec              (vec_q),
        .ha_sum           (ha_sum),
        .ha_carry         (ha_carry),
        .err_count        (err_count),
        .first_fail_vec   (bus.first_fail_vec),
        .first_fail_valid (bus.first_fail_valid),
`ifdef HA_BIST_FAULT_CLASS_EN
        .sum_mask         (sum_mask),
        .carry_mask       (carry_mask),
`endif
        .fail_mask        (bus.fail_mask)
    );

`ifdef HA_BIST_FAULT_CLASS_EN
    // Classification refreshed on normal completion only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_class_q <= FcNone;
        end else if (clear) begin
            fault_class_q <= FcNone;
        end else if (state_q == StDone) begin
            fault_class_q <= ha_fault_class(sum_mask, carry_mask);
        end
    end

    assign bus.fault_class = fault_class_q;
`endif

    assign ha_a          = ha_q[1];
    assign ha_b          = ha_q[0];
    assign bus.err_count = err_count;
    assign bus.busy      = (state_q == StApply) || (state_q == StCheck);
    assign bus.done      = (state_q == StDone);
    // Result is visible during the done pulse and held afterwards
    assign bus.pass      = (state_q == StDone) ? (err_count == '0) : pass_q;

endmodule

// File: tb/tb_ha_bist_ctrl.sv
// Directed bench for ha_bist_ctrl: three instances cover default, PASSES=2
// and CNT_W=2/PASSES=2; a behavioural half adder per instance takes a fault select.
module tb_ha_bist_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // fault select: 0 none, 1 sum stuck-at-0, 2 carry stuck-at-1
    int f0 = 0, f1 = 0, f2 = 0;

    logic a0, b0, s0, c0;
    logic a1, b1, s1, c1;
    logic a2, b2, s2, c2;

    assign s0 = (f0 == 1) ? 1'b0 : (a0 ^ b0);
    assign c0 = (f0 == 2) ? 1'b1 : (a0 & b0);
    assign s1 = (f1 == 1) ? 1'b0 : (a1 ^ b1);
    assign c1 = (f1 == 2) ? 1'b1 : (a1 & b1);
    assign s2 = (f2 == 1) ? 1'b0 : (a2 ^ b2);
    assign c2 = (f2 == 2) ? 1'b1 : (a2 & b2);

    ha_bist_ctrl_if #(.CNT_W(8)) bus0 ();
    ha_bist_ctrl_if #(.CNT_W(8)) bus1 ();
    ha_bist_ctrl_if #(.CNT_W(2)) bus2 ();

    ha_bist_ctrl u_dut0 (
        .clk (clk), .rst_n (rst_n), .bus (bus0),
        .ha_a (a0), .ha_b (b0), .ha_sum (s0), .ha_carry (c0)
    );

    ha_bist_ctrl #(.PASSES(2), .SETTLE(1), .CNT_W(8)) u_dut1 (
        .clk (clk), .rst_n (rst_n), .bus (bus1),
        .ha_a (a1), .ha_b (b1), .ha_sum (s1), .ha_carry (c1)
    );

    ha_bist_ctrl #(.PASSES(2), .SETTLE(1), .CNT_W(2)) u_dut2 (
        .clk (clk), .rst_n (rst_n), .bus (bus2),
        .ha_a (a2), .ha_b (b2), .ha_sum (s2), .ha_carry (c2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic done_of(input int sel);
        if (sel == 0) return bus0.done;
        if (sel == 1) return bus1.done;
        return bus2.done;
    endfunction

    // Cycles counted from the edge that samples start (that edge is cycle 1)
    task automatic wait_done(input int sel, input int cyc_in, output int cyc_out);
        int cyc;
        cyc = cyc_in;
        while (done_of(sel) !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
        cyc_out = cyc;
    endtask

    task automatic start0();
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
    endtask

    initial begin
        int cyc;
        bit seen_done;
        bus0.start = 1'b0; bus0.abort = 1'b0;
        bus1.start = 1'b0; bus1.abort = 1'b0;
        bus2.start = 1'b0; bus2.abort = 1'b0;

        // Reset values
        #3;
        chk("rst_busy", bus0.busy, 0);
        chk("rst_done", bus0.done, 0);
        chk("rst_pass", bus0.pass, 0);
        chk("rst_err", bus0.err_count, 0);
        chk("rst_ffvalid", bus0.first_fail_valid, 0);
        chk("rst_ffvec", bus0.first_fail_vec, 0);
        chk("rst_mask", bus0.fail_mask, 0);
        chk("rst_ha", {a0, b0}, 0);
`ifdef HA_BIST_FAULT_CLASS_EN
        chk("rst_fc", bus0.fault_class, 0);
`endif
        #4 rst_n = 1'b1;
        tick();

        // Fault-free run, default parameters
        start0();
        chk("ok_busy", bus0.busy, 1);
        wait_done(0, 1, cyc);
        chk("ok_latency", cyc, 9);
        chk("ok_pass_at_done", bus0.pass, 1);
        chk("ok_err", bus0.err_count, 0);
        chk("ok_mask", bus0.fail_mask, 0);
        chk("ok_ffvalid", bus0.first_fail_valid, 0);
        tick();
        chk("ok_done_pulse", bus0.done, 0);
        chk("ok_busy_after", bus0.busy, 0);
        chk("ok_pass_held", bus0.pass, 1);
        chk("ok_ha_idle", {a0, b0}, 0);
`ifdef HA_BIST_FAULT_CLASS_EN
        chk("ok_fc", bus0.fault_class, 0);
`endif

        // abort in IDLE is ignored and leaves the result alone
        bus0.abort = 1'b1;
        tick();
        tick();
        bus0.abort = 1'b0;
        chk("idle_abort_busy", bus0.busy, 0);
        chk("idle_abort_pass", bus0.pass, 1);

        // Sum stuck-at-0: vectors 01 and 10 fail
        f0 = 1;
        start0();
        wait_done(0, 1, cyc);
        chk("ssa0_latency", cyc, 9);
        chk("ssa0_pass", bus0.pass, 0);
        tick();
        chk("ssa0_err", bus0.err_count, 2);
        chk("ssa0_mask", bus0.fail_mask, 4'b0110);
        chk("ssa0_ffvec", bus0.first_fail_vec, 2'b01);
        chk("ssa0_ffvalid", bus0.first_fail_valid, 1);
        chk("ssa0_pass_held", bus0.pass, 0);
`ifdef HA_BIST_FAULT_CLASS_EN
        chk("ssa0_fc", bus0.fault_class, 1);
`endif

        // PASSES=2, carry stuck-at-1: 00,01,10 fail in each sweep
        f1 = 2;
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        wait_done(1, 1, cyc);
        chk("csa1_latency", cyc, 17);
        tick();
        chk("csa1_err", bus1.err_count, 6);
        chk("csa1_mask", bus1.fail_mask, 4'b0111);
        chk("csa1_ffvec", bus1.first_fail_vec, 2'b00);
        chk("csa1_pass", bus1.pass, 0);
`ifdef HA_BIST_FAULT_CLASS_EN
        chk("csa1_fc", bus1.fault_class, 4);
`endif

        // CNT_W=2: six mismatches saturate at 3
        f2 = 2;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        wait_done(2, 1, cyc);
        chk("sat_latency", cyc, 17);
        tick();
        chk("sat_err", bus2.err_count, 3);
        chk("sat_mask", bus2.fail_mask, 4'b0111);

        // Fault-free run aborted in cycle 3 (APPLY of vector 01)
        f0 = 0;
        start0();
        tick();
        tick();
        chk("abort_ha_vec1", {a0, b0}, 2'b01);
        bus0.abort = 1'b1;
        tick();
        bus0.abort = 1'b0;
        chk("abort_busy", bus0.busy, 0);
        chk("abort_ha", {a0, b0}, 0);
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus0.done === 1'b1) seen_done = 1'b1;
            tick();
        end
        chk("abort_no_done", seen_done, 0);
        chk("abort_pass", bus0.pass, 0);
        start0();
        wait_done(0, 1, cyc);
        chk("rerun_latency", cyc, 9);
        chk("rerun_pass", bus0.pass, 1);
        tick();

        // Abort during CHECK of a failing vector still records it
        f0 = 1;
        start0();
        tick();
        tick();
        tick();
        bus0.abort = 1'b1;
        tick();
        bus0.abort = 1'b0;
        chk("abchk_busy", bus0.busy, 0);
        chk("abchk_err", bus0.err_count, 1);
        chk("abchk_mask", bus0.fail_mask, 4'b0010);
        chk("abchk_ffvec", bus0.first_fail_vec, 2'b01);
        chk("abchk_ffvalid", bus0.first_fail_valid, 1);
        chk("abchk_pass", bus0.pass, 0);
        tick();
        chk("abchk_frozen", bus0.err_count, 1);

        // start re-pulsed mid-run has no effect on timing
        f0 = 0;
        start0();
        tick();
        tick();
        tick();
        bus0.start = 1'b1;
        tick();
        bus0.start = 1'b0;
        wait_done(0, 5, cyc);
        chk("repulse_latency", cyc, 9);
        chk("repulse_pass", bus0.pass, 1);
        tick();

        // start and abort together in IDLE: start wins
        bus0.start = 1'b1;
        bus0.abort = 1'b1;
        tick();
        bus0.start = 1'b0;
        bus0.abort = 1'b0;
        chk("startabort_busy", bus0.busy, 1);
        wait_done(0, 1, cyc);
        chk("startabort_latency", cyc, 9);
        tick();

        // Asynchronous reset mid-run
        f0 = 1;
        start0();
        for (int i = 0; i < 4; i++) tick();
        chk("midrst_ha_vec2", {a0, b0}, 2'b10);
        chk("midrst_err_before", bus0.err_count, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", bus0.busy, 0);
        chk("midrst_ha", {a0, b0}, 0);
        chk("midrst_err", bus0.err_count, 0);
        chk("midrst_mask", bus0.fail_mask, 0);
        chk("midrst_ffvalid", bus0.first_fail_valid, 0);
        chk("midrst_pass", bus0.pass, 0);
        rst_n = 1'b1;
        tick();
        chk("midrst_idle", bus0.busy, 0);
        tick();
        chk("midrst_still_idle", {bus0.busy, bus0.done, a0, b0}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ha_bist_ctrl.md
Name: ha_bist_ctrl

Overview:
Built-in self-test sequencer for the 1-bit half adder and its fault-injected variants.
- On start, drives the exhaustive input sweep into the half adder under test and compares its sum/carry against a golden model.
- Counts mismatches, records the first failing vector and reports pass/fail.
- Sits beside the half adder instance; replaces hand-written stimulus for fault campaigns.

Parameters:
PASSES, 1, number of full 4-vector sweeps per run (>=1)
SETTLE, 1, cycles each vector is held before sampling (>=1)
CNT_W, 8, width of mismatch counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin run; sampled only in IDLE
abort  in  1  terminate run; sampled while busy
ha_a  out  1  half adder input a
ha_b  out  1  half adder input b
ha_sum  in  1  half adder sum output
ha_carry  in  1  half adder carry output
busy  out  1  run in progress
done  out  1  one-cycle pulse, run completed normally
pass  out  1  last completed run had zero mismatches
err_count  out  CNT_W  mismatches in last/current run, saturating
first_fail_vec  out  2  {a,b} of first mismatch
first_fail_valid  out  1  first_fail_vec holds a captured value
fail_mask  out  4  bit i set if vector i ({a,b}=i) mismatched at least once

Behaviour:
- Reset (async, rst_n=0): state IDLE. ha_a=ha_b=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0, fail_mask=0.
- Vector order: 00,01,10,11, with a=vec[1], b=vec[0]. Golden model: sum=a^b, carry=a&b. Mismatch = either output differs.
- States: IDLE, APPLY, CHECK, DONE.
- IDLE:
  - start=1: clear err_count, first_fail_*, fail_mask and pass.
  - Set vec=0, pass counter=0, go to APPLY; busy=1 from the next cycle.
- APPLY:
  - ha_a/ha_b driven from vec.
  - Held SETTLE cycles (settle counter), then go to CHECK.
- CHECK (1 cycle): vec still driven; compare ha_sum/ha_carry combinationally against golden. On mismatch:
  - err_count+1, saturating at 2^CNT_W-1.
  - fail_mask[vec] set.
  - If !first_fail_valid, capture vec and set first_fail_valid.
- After CHECK:
  - vec<3: vec+1, go to APPLY.
  - vec==3 and pass counter<PASSES-1: vec wraps to 0, pass counter+1, go to APPLY.
  - Otherwise go to DONE.
- DONE (1 cycle):
  - done=1, pass=(err_count==0), busy=0.
  - ha_a/ha_b return to 0. Go to IDLE.
- Latency: start-to-done = 1 + PASSES*4*(SETTLE+1) cycles (done asserted in cycle N after the start edge).
- abort while busy (APPLY/CHECK):
  - Go to IDLE next cycle; busy=0, done stays 0, pass=0.
  - err_count/fail_mask/first_fail_* frozen at partial values.
  - A mismatch in the abort cycle's CHECK is still recorded.
- start while busy or in DONE: ignored. abort in IDLE: ignored. start and abort in the same IDLE cycle: start wins.
- ha_a/ha_b are registered outputs, glitch-free.

Optional Feature:
Macro HA_BIST_FAULT_CLASS_EN.
- Defined:
  - Internal sum_mask[3:0] and carry_mask[3:0], set per failing output.
  - Extra output fault_class[2:0], updated in DONE and reset to 0. Codes:
    - 0 NONE: both masks 0.
    - 1 SUM_SA0: sum_mask=0110, carry_mask=0.
    - 2 SUM_SA1: sum_mask=1001, carry_mask=0.
    - 3 CARRY_SA0: carry_mask=1000, sum_mask=0.
    - 4 CARRY_SA1: carry_mask=0111, sum_mask=0.
    - 7 UNKNOWN: any other pattern.
  - Cleared on start; unchanged on abort.
- Undefined: no fault_class port and no per-output masks.

Decomposition:
- Package ha_bist_pkg:
  - State enum.
  - Vector count constant (4).
  - fault_class code constants.
  - Golden-model function ha_golden(a,b) returning {carry,sum}.
- One sub-module ha_bist_checker (combinational compare plus mask/counter/first-fail registers). FSM and counters stay in ha_bist_ctrl.

Test Plan:
- Default parameters, fault-free half adder, start pulse → done at cycle 9, pass=1, err_count=0, fail_mask=0000, first_fail_valid=0, fault_class=0.
- Sum stuck-at-0 → err_count=2, fail_mask=0110, first_fail_vec=01, pass=0, fault_class=1.
- PASSES=2, carry stuck-at-1 → err_count=6, fail_mask=0111, first_fail_vec=00, fault_class=4, done at cycle 17.
- CNT_W=2, PASSES=2, carry stuck-at-1 → err_count saturates at 3, fail_mask=0111.
- Fault-free run, abort at cycle 3:
  - busy=0 next cycle, done never pulses, pass=0.
  - Subsequent start → full run, pass=1.
- start re-pulsed mid-run → ignored, done timing unchanged. rst_n low mid-run → all outputs at reset values immediately (async), FSM in IDLE.
